shift_reg: RTL and testbench

SHIFT_REG -- requirements
Module: shift_reg

---
 rtl/shift_reg_if.sv | 22 ++
 rtl/shift_reg.sv | 33 +++
 tb/tb_shift_reg.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/shift_reg_if.sv
// Control and data bundle for shift_reg: the master side drives the enables and
// load data, the slave side (the register) returns its contents.
interface shift_reg_if #(
   parameter int LUNGIME = 4
);
   logic               shift_n;
   logic               load_n;
   logic               s_in;
   logic [LUNGIME-1:0] p_in;
   logic [LUNGIME-1:0] p_out;
   logic               s_out;

   modport master (
      output shift_n, load_n, s_in, p_in,
      input  p_out, s_out
   );

   modport slave (
      input  shift_n, load_n, s_in, p_in,
      output p_out, s_out
   );
endinterface

// File: rtl/shift_reg.sv
// LUNGIME-bit right-shift register with synchronous reset, parallel load and
// serial input at the MSB; priority per edge is reset, load, shift, hold.
module shift_reg #(
   parameter int LUNGIME = 4
) (
   input logic        clk,
   input logic        rst,
   shift_reg_if.slave bus
);

   if (LUNGIME < 2 || LUNGIME > 64) begin : g_width_check
      $error("shift_reg: LUNGIME must be in 2..64");
   end

   logic [LUNGIME-1:0] r;

   // NOTE: the register is updated only with non-blocking assignments, and reset
   // is sampled inside the clocked block so it takes effect only at an edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         r <= '0;
      end else if (!bus.load_n) begin
         r <= bus.p_in;
      end else if (!bus.shift_n) begin
         r <= {bus.s_in, r[LUNGIME-1:1]};
      end
   end

   // Outputs come straight from the register, so no input reaches them combinationally.
   assign bus.p_out = r;
   assign bus.s_out = r[0];

endmodule

// File: tb/tb_shift_reg.sv
// Self-checking bench for shift_reg: directed vector table, a hand-written serial
// traversal, then randomized traffic against an arithmetic reference model.
module tb_shift_reg;

   localparam int W = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   shift_reg_if #(.LUNGIME(W)) bus ();
   shift_reg #(.LUNGIME(W)) dut (.clk(clk), .rst(rst), .bus(bus));

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic         rst;
      logic         load_n;
      logic         shift_n;
      logic         s_in;
      logic [W-1:0] p_in;
      logic [W-1:0] exp;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic l, input logic s, input logic si,
                      input logic [W-1:0] p, input logic [W-1:0] e);
      vec_t v;
      v.rst = r; v.load_n = l; v.shift_n = s; v.s_in = si; v.p_in = p; v.exp = e;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive one set of inputs, let one rising edge sample them, then settle.
   task automatic apply(input logic r, input logic l, input logic s, input logic si,
                        input logic [W-1:0] p);
      rst = r; bus.load_n = l; bus.shift_n = s; bus.s_in = si; bus.p_in = p;
      @(posedge clk);
      #1;
   endtask

   // Reference: the register as an integer, updated from the priority rules.
   function automatic logic [W-1:0] model_next(input logic [W-1:0] cur, input logic r,
                                               input logic l, input logic s,
                                               input logic si, input logic [W-1:0] p);
      int unsigned v;
      if (r) return '0;
      if (!l) return p;
      if (!s) begin
         v = (int'(cur) / 2) + (int'(si) * (2 ** (W - 1)));
         return W'(v);
      end
      return cur;
   endfunction

   bit started = 1'b0;
   always @(posedge clk) begin
      if (started && $isunknown({rst, bus.load_n, bus.shift_n})) begin
         fails++;
         $display("FAIL x_on_control: got rst=%b load_n=%b shift_n=%b expected known values",
                  rst, bus.load_n, bus.shift_n);
      end
   end

   initial begin
      logic [W-1:0] model;
      logic         r, l, s, si;
      logic [W-1:0] p;

      rst = 1'b1; bus.load_n = 1'b1; bus.shift_n = 1'b1; bus.s_in = 1'b0; bus.p_in = '0;
      started = 1'b1;

      //   rst load_n shift_n s_in p_in     expected p_out
      add(1, 1, 1, 0, 4'b0000, 4'b0000); // initial reset
      add(0, 0, 1, 0, 4'b1011, 4'b1011); // preload 1011
      add(1, 0, 0, 0, 4'b1111, 4'b0000); // reset beats load
      add(0, 0, 1, 0, 4'b0000, 4'b0000); // load 0000
      add(0, 1, 1, 0, 4'b0001, 4'b0000); // hold, p_in changed
      add(0, 1, 1, 1, 4'b0001, 4'b0000); // hold, s_in changed
      add(0, 0, 1, 0, 4'b0001, 4'b0001); // load 0001
      add(0, 0, 1, 0, 4'b0000, 4'b0000); // back to 0000
      add(0, 1, 0, 0, 4'b1111, 4'b0000); // shift zeros x4
      add(0, 1, 0, 0, 4'b1111, 4'b0000);
      add(0, 1, 0, 0, 4'b1111, 4'b0000);
      add(0, 1, 0, 0, 4'b1111, 4'b0000);
      add(0, 1, 0, 1, 4'b0000, 4'b1000); // shift ones
      add(0, 1, 0, 1, 4'b0000, 4'b1100);
      add(0, 0, 1, 0, 4'b0000, 4'b0000); // serial traversal 1,0,0,0
      add(0, 1, 0, 1, 4'b0000, 4'b1000);
      add(0, 1, 0, 0, 4'b0000, 4'b0100);
      add(0, 1, 0, 0, 4'b0000, 4'b0010);
      add(0, 1, 0, 0, 4'b0000, 4'b0001);
      add(0, 0, 0, 1, 4'b1010, 4'b1010); // load wins over shift
      add(1, 1, 1, 0, 4'b0000, 4'b0000); // reset mid-shift
      add(0, 1, 0, 1, 4'b0000, 4'b1000);
      add(0, 1, 0, 1, 4'b0000, 4'b1100);
      add(1, 1, 0, 1, 4'b0000, 4'b0000);
      add(0, 1, 0, 1, 4'b0000, 4'b1000); // restarts from zero
      add(0, 1, 1, 0, 4'b1111, 4'b1000); // hold

      foreach (vecs[i]) begin
         apply(vecs[i].rst, vecs[i].load_n, vecs[i].shift_n, vecs[i].s_in, vecs[i].p_in);
         check($sformatf("vec%0d_p_out", i), 64'(bus.p_out), 64'(vecs[i].exp));
         check($sformatf("vec%0d_s_out", i), 64'(bus.s_out), 64'(vecs[i].exp[0]));
      end

      // A lone 1 must appear on s_out at exactly the W-th shift edge, not before.
      apply(1, 1, 1, 0, '0);
      for (int k = 1; k <= W; k++) begin
         apply(0, 1, 0, (k == 1), '0);
         check($sformatf("traverse_edge%0d_s_out", k), 64'(bus.s_out), 64'(k == W));
      end
      apply(0, 1, 0, 0, '0);
      check("traverse_flushed_p_out", 64'(bus.p_out), 64'd0);

      apply(1, 1, 1, 0, '0);
      model = '0;
      for (int n = 0; n < 600; n++) begin
         r  = ($urandom_range(31) == 0);
         l  = ($urandom_range(3) != 0);
         s  = $urandom_range(1);
         si = $urandom_range(1);
         p  = W'($urandom);
         apply(r, l, s, si, p);
         model = model_next(model, r, l, s, si, p);
         check($sformatf("rand%0d_p_out", n), 64'(bus.p_out), 64'(model));
         check($sformatf("rand%0d_s_out", n), 64'(bus.s_out), 64'(model[0]));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
